// File: rtl/ic_pkg.sv
// Shared instruction-cache definitions: PLRU tree types, sizing constants and
// the tree walk helpers used by both the PLRU store and its verification model.
package ic_pkg;

  localparam int IC_WAYS     = 4;
  localparam int IC_LINES    = 256;
  localparam int PLRU_MAX_TB = 7;   // widest tree supported (8 ways)
  localparam int PLRU_MAX_WW = 3;

  typedef logic [IC_WAYS-2:0]         ic_plru_t;
  typedef logic [$clog2(IC_WAYS)-1:0] ic_way_t;
  typedef logic [PLRU_MAX_TB-1:0]     plru_vec_t;
  typedef logic [PLRU_MAX_WW-1:0]     plru_idx_t;

  typedef enum int {BEHAVIORAL, GOWIN} ic_impl_e;
  typedef enum logic {ST_INIT, ST_RUN} plru_state_e;

  function automatic int plru_levels(input int ways);
    int n;
    n = 0;
    for (int i = 0; i < PLRU_MAX_WW; i++)
      if ((1 << i) < ways) n++;
    return n;
  endfunction

  // Walk from the root; each node bit picks the half holding the victim.
  function automatic plru_idx_t plru_victim(input plru_vec_t bits, input int ways = IC_WAYS);
    plru_idx_t node;
    plru_idx_t way;
    node = '0;
    way  = '0;
    for (int lvl = 0; lvl < PLRU_MAX_WW; lvl++) begin
      if (lvl < plru_levels(ways)) begin
        way  = {way[PLRU_MAX_WW-2:0], bits[node]};
        node = (node << 1) + plru_idx_t'(1) + plru_idx_t'(bits[node]);
      end
    end
    return way;
  endfunction

  function automatic plru_vec_t plru_touch(input plru_vec_t bits, input plru_idx_t way,
                                           input int ways = IC_WAYS);
    plru_vec_t nb;
    plru_idx_t node;
    plru_idx_t sh;
    int        lv;
    nb   = bits;
    node = '0;
    lv   = plru_levels(ways);
    sh   = way << (PLRU_MAX_WW - lv);
    for (int lvl = 0; lvl < PLRU_MAX_WW; lvl++) begin
      if (lvl < lv) begin
        nb[node] = ~sh[PLRU_MAX_WW-1];
        node     = (node << 1) + plru_idx_t'(1) + plru_idx_t'(sh[PLRU_MAX_WW-1]);
        sh       = sh << 1;
      end
    end
    return nb;
  endfunction

endpackage

// File: rtl/ic_plru_mem.sv
// Simple dual-port 1R1W RAM holding the PLRU tree bits, one word per line.
// Read data is registered; the Gowin variant is shaped for DPB inference.
module ic_plru_mem
  import ic_pkg::*;
#(
  parameter int       LINES = IC_LINES,
  parameter int       TB    = IC_WAYS - 1,
  parameter ic_impl_e IMPL  = BEHAVIORAL,
  localparam int      LW    = $clog2(LINES)
) (
  input  logic          clk,
  input  logic          i_rd_en,
  input  logic [LW-1:0] i_rd_addr,
  output logic [TB-1:0] o_rd_data,
  input  logic          i_wr_en,
  input  logic [LW-1:0] i_wr_addr,
  input  logic [TB-1:0] i_wr_data
);

  // NOTE: the array has no reset; the owner's init sweep clears every line.
  logic [TB-1:0] r_mem [LINES];

  generate
    if (IMPL == BEHAVIORAL) begin : g_beh
      // NOTE: non-blocking assignments keep read-before-write ordering exact.
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
      end
    end else if (IMPL == GOWIN) begin : g_gowin
      // Port A: read with clock enable, no output register stage.
      always_ff @(posedge clk) begin
        if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
      end
      // Port B: write only.
      always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
      end
    end else begin : g_bad
      $error("ic_plru_mem: unsupported IMPL value");
    end
  endgenerate

endmodule

// File: rtl/ic_plru_ram.sv
// Tree-pseudo-LRU state store: init/flush sweep, 1-cycle lookup/touch pipeline
// with read-modify-write and same-line forwarding between consecutive requests.
module ic_plru_ram
  import ic_pkg::*;
#(
  parameter int       WAYS  = IC_WAYS,
  parameter int       LINES = IC_LINES,
  parameter ic_impl_e IMPL  = BEHAVIORAL,
  localparam int      TB    = WAYS - 1,
  localparam int      LW    = $clog2(LINES),
  localparam int      WW    = $clog2(WAYS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  output logic          req_ready,
  input  logic          req_valid,
  input  logic [LW-1:0] req_line,
  input  logic          req_touch,
  input  logic [WW-1:0] req_way,
  output logic          rsp_valid,
  output logic [TB-1:0] rsp_bits,
  output logic [WW-1:0] rsp_victim
);

  plru_state_e   r_state, w_state_nxt;
  logic [LW-1:0] r_cnt, w_cnt_nxt;
  logic          r_s1_valid, r_s1_touch, r_fwd;
  logic [LW-1:0] r_s1_line;
  logic [WW-1:0] r_s1_way;
  logic [TB-1:0] r_fwd_bits;

  logic          w_accept, w_collide, w_s1_we;
  logic [TB-1:0] w_rd_data, w_cur_bits, w_new_bits;
  logic          w_wr_en;
  logic [LW-1:0] w_wr_addr;
  logic [TB-1:0] w_wr_data;

  // Outputs are gated by rst_n so a pending op vanishes in the reset cycle itself.
  assign req_ready  = rst_n & (r_state == ST_RUN);
  assign w_accept   = req_valid & req_ready & ~flush;
  assign rsp_valid  = rst_n & r_s1_valid;
  assign w_s1_we    = rsp_valid & r_s1_touch;
  assign w_collide  = w_accept & w_s1_we & (req_line == r_s1_line);

  assign w_cur_bits = r_fwd ? r_fwd_bits : w_rd_data;
  assign w_new_bits = TB'(plru_touch(PLRU_MAX_TB'(w_cur_bits), PLRU_MAX_WW'(r_s1_way), WAYS));
  assign rsp_bits   = rsp_valid ? w_cur_bits : '0;
  assign rsp_victim = rsp_valid ? WW'(plru_victim(PLRU_MAX_TB'(w_cur_bits), WAYS)) : '0;

  always_comb begin
    // NOTE: defaults first so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_s1_line;
    w_wr_data   = w_new_bits;
    unique case (r_state)
      ST_INIT: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_cnt;
        w_wr_data = '0;
        if (flush) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + LW'(1);
          if (r_cnt == LW'(LINES - 1)) w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_wr_en = w_s1_we;
        if (flush) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_cnt      <= '0;
      r_s1_valid <= 1'b0;
      r_fwd      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_s1_valid <= w_accept;
      r_fwd      <= w_collide;
    end
  end

  // Datapath registers are qualified by r_s1_valid / r_fwd and need no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_line  <= req_line;
      r_s1_touch <= req_touch;
      r_s1_way   <= req_way;
    end
    if (w_collide) r_fwd_bits <= w_new_bits;
  end

  ic_plru_mem #(
    .LINES (LINES),
    .TB    (TB),
    .IMPL  (IMPL)
  ) u_mem (
    .clk       (clk),
    .i_rd_en   (w_accept & ~w_collide),
    .i_rd_addr (req_line),
    .o_rd_data (w_rd_data),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (w_wr_data)
  );

endmodule

// File: tb/tb_ic_plru_ram.sv
// Bench for ic_plru_ram (4 ways, 16 lines): per-line tree model with a
// per-cycle comparator, plus directed sequences with literal expectations.
module tb_ic_plru_ram;
  import ic_pkg::*;

  localparam int WAYS  = 4;
  localparam int LINES = 16;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       flush     = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_touch = 1'b0;
  logic [3:0] req_line  = '0;
  logic [1:0] req_way   = '0;
  logic       req_ready, rsp_valid;
  logic [2:0] rsp_bits;
  logic [1:0] rsp_victim;

  int n_checks = 0;
  int n_errors = 0;

  ic_plru_ram #(.WAYS(WAYS), .LINES(LINES), .IMPL(BEHAVIORAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_ready  (req_ready),
    .req_valid  (req_valid),
    .req_line   (req_line),
    .req_touch  (req_touch),
    .req_way    (req_way),
    .rsp_valid  (rsp_valid),
    .rsp_bits   (rsp_bits),
    .rsp_victim (rsp_victim)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model tree: leaf for way w is heap node w+WAYS-1; climb to the root and
  // make each ancestor point at the sibling subtree.
  function automatic logic [2:0] m_touch(input logic [2:0] b, input int way);
    int v;
    int n;
    v = int'(b);
    n = way + WAYS - 1;
    while (n > 0) begin
      int p;
      p = (n - 1) / 2;
      if (n % 2 == 1) v = v | (1 << p);
      else            v = v & ~(1 << p);
      n = p;
    end
    return 3'(v);
  endfunction

  function automatic logic [1:0] m_victim(input logic [2:0] b);
    int n;
    n = 0;
    for (int l = 0; l < $clog2(WAYS); l++) n = 2 * n + 1 + ((int'(b) >> n) & 1);
    return 2'(n - (WAYS - 1));
  endfunction

  logic [2:0] m_mem [LINES];
  int         m_init_left = LINES;
  bit         m_pend      = 1'b0;
  bit         m_pend_touch;
  int         m_pend_line, m_pend_way;
  logic [2:0] m_pend_bits;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_init_left = LINES;
      m_pend      = 1'b0;
    end else begin
      if (m_pend && m_pend_touch) m_mem[m_pend_line] = m_touch(m_mem[m_pend_line], m_pend_way);
      m_pend = 1'b0;
      if (flush) begin
        m_init_left = LINES;
      end else if (m_init_left > 0) begin
        m_init_left--;
        if (m_init_left == 0) foreach (m_mem[i]) m_mem[i] = '0;
      end else if (req_valid) begin
        m_pend       = 1'b1;
        m_pend_touch = req_touch;
        m_pend_line  = int'(req_line);
        m_pend_way   = int'(req_way);
        m_pend_bits  = m_mem[int'(req_line)];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    check("req_ready", req_ready, rst_n && m_init_left == 0);
    check("rsp_valid", rsp_valid, m_pend && rst_n);
    if (m_pend && rst_n) begin
      check("rsp_bits", rsp_bits, m_pend_bits);
      check("rsp_victim", rsp_victim, m_victim(m_pend_bits));
    end
  end

  task automatic drive(input logic v, input logic t, input int line, input int way,
                       input logic fl = 1'b0);
    @(posedge clk);
    #1;
    req_valid = v;
    req_touch = t;
    req_line  = 4'(line);
    req_way   = 2'(way);
    flush     = fl;
  endtask

  task automatic lit(input string nm, input logic [2:0] b, input logic [1:0] v);
    @(negedge clk);
    check({nm, ".valid"}, rsp_valid, 1);
    check({nm, ".bits"}, rsp_bits, b);
    check({nm, ".victim"}, rsp_victim, v);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
  endtask

  int chain[8] = '{1, 3, 0, 2, 3, 1, 0, 1};

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", req_ready, 0);
    check("rst.valid", rsp_valid, 0);
    check("rst.bits", rsp_bits, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("init.len", n, 16);

    for (int i = 0; i < LINES; i++) drive(1, 0, i, 0);
    drive(0, 0, 0, 0);
    lit("look15", 3'b000, 2'd0);

    // consecutive touches of one line: forwarding chains twice
    drive(1, 1, 5, 0);
    drive(1, 1, 5, 2);
    lit("b2b.0", 3'b000, 2'd0);
    drive(1, 0, 5, 0);
    lit("b2b.1", 3'b011, 2'd2);
    drive(0, 0, 0, 0);
    lit("b2b.2", 3'b110, 2'd1);

    // flush with a touch in flight and a request that must be dropped
    drive(1, 1, 7, 3);
    drive(1, 0, 7, 0, 1'b1);
    lit("flush.rsp", 3'b000, 2'd0);
    drive(0, 0, 0, 0);
    wait_ready(n);
    check("flush.len", n, 16);
    drive(1, 0, 7, 0);
    drive(1, 0, 5, 0);
    lit("flush.l7", 3'b000, 2'd0);
    drive(0, 0, 0, 0);
    lit("flush.l5", 3'b000, 2'd0);

    drive(1, 1, 5, 0);
    drive(0, 0, 0, 0);
    lit("t5.rsp", 3'b000, 2'd0);
    drive(1, 0, 5, 0);
    drive(0, 0, 0, 0);
    lit("t5.look", 3'b011, 2'd2);

    drive(1, 1, 3, 1);
    drive(1, 0, 4, 0);
    lit("x.t3", 3'b000, 2'd0);
    drive(1, 0, 3, 0);
    lit("x.l4", 3'b000, 2'd0);
    drive(0, 0, 0, 0);
    lit("x.l3", 3'b001, 2'd2);

    // long forwarding chain on line 9, interleaved with line 10
    foreach (chain[i]) drive(1, 1, 9, chain[i]);
    drive(1, 0, 9, 0);
    drive(1, 1, 10, 2);
    lit("chain.end", 3'b001, 2'd2);
    drive(1, 0, 9, 0);
    drive(1, 0, 10, 0);
    drive(0, 0, 0, 0);

    // reset while a touch of line 2 sits in the response stage
    drive(1, 1, 2, 1);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst.drop", rsp_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready(n);
    check("reinit.len", n, 16);
    drive(1, 0, 2, 0);
    drive(0, 0, 0, 0);
    lit("rst.l2", 3'b000, 2'd0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "timeout");
  end

endmodule
